// File: rtl/binary_fc_argmax.sv
// Binarized fully-connected classifier with sequential argmax, one neuron per cycle.
// Optional macro BINARY_FC_SCORE_OUT_EN builds the per-neuron score_out registers.
module binary_fc_argmax #(
  parameter int IN_W  = 16,
  parameter int N_OUT = 10,
  parameter int SC_W  = 5,
  parameter int CLS_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_flag,
  input  logic [IN_W-1:0]       in,
  input  logic [N_OUT*IN_W-1:0] weight_in,
  output logic [CLS_W-1:0]      class_out,
  output logic [SC_W-1:0]       max_score,
  output logic [N_OUT*SC_W-1:0] score_out,
  output logic                  busy,
  output logic                  end_flag,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CLS_W-1:0] idx_q;
  logic [IN_W-1:0]  in_lat;
  logic [SC_W-1:0]  run_max;
  logic [CLS_W-1:0] run_cls;
  logic [IN_W-1:0]  w_cur;
  logic [SC_W-1:0]  s_cur;
  logic             last_neuron;

  function automatic logic [SC_W-1:0] popcount(input logic [IN_W-1:0] v);
    logic [SC_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < IN_W; i++) cnt = cnt + SC_W'(v[i]);
    return cnt;
  endfunction

  assign w_cur       = weight_in[idx_q*IN_W +: IN_W];
  assign s_cur       = popcount(~(in_lat ^ w_cur));
  assign last_neuron = (idx_q == CLS_W'(N_OUT-1));
  assign state_dbg   = state_q;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_flag) state_d = S_RUN;
      S_RUN:    if (last_neuron) state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      idx_q     <= '0;
      in_lat    <= '0;
      run_max   <= '0;
      run_cls   <= '0;
      class_out <= '0;
      max_score <= '0;
      busy      <= 1'b0;
      end_flag  <= 1'b0;
    end else begin
      end_flag <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_flag) begin
            in_lat  <= in;
            idx_q   <= '0;
            run_max <= '0;
            run_cls <= '0;
            busy    <= 1'b1;
          end
        end
        S_RUN: begin
          // Strict compare keeps the lowest index on ties.
          if (idx_q == '0 || s_cur > run_max) begin
            run_max <= s_cur;
            run_cls <= idx_q;
          end
          idx_q <= idx_q + 1'b1;
        end
        S_FINISH: begin
          class_out <= run_cls;
          max_score <= run_max;
          end_flag  <= 1'b1;
          busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef BINARY_FC_SCORE_OUT_EN
  logic [N_OUT*SC_W-1:0] score_q;

  always_ff @(posedge clk) begin
    if (!reset)                score_q <= '0;
    else if (state_q == S_RUN) score_q[idx_q*SC_W +: SC_W] <= s_cur;
  end

  assign score_out = score_q;
`else
  assign score_out = '0;
`endif

endmodule

// File: tb/tb_binary_fc_argmax.sv
// Scoreboard bench for binary_fc_argmax: reference argmax model, latency and pulse checks.
module tb_binary_fc_argmax;
  localparam int IN_W  = 16;
  localparam int N_OUT = 10;
  localparam int SC_W  = 5;
  localparam int CLS_W = 4;
  localparam int W     = CLS_W + SC_W + N_OUT*SC_W;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  start_flag = 1'b0;
  logic [IN_W-1:0]       in = '0;
  logic [N_OUT*IN_W-1:0] weight_in = '0;
  logic [CLS_W-1:0]      class_out;
  logic [SC_W-1:0]       max_score;
  logic [N_OUT*SC_W-1:0] score_out;
  logic                  busy;
  logic                  end_flag;
  logic [1:0]            state_dbg;

  int checks = 0;
  int failures = 0;
  int ends_seen = 0;
  int cyc = 0;
  int t0 = 0;
  int lat;
  logic prev_end = 1'b0;
  logic [W-1:0] exp_q[$];

  binary_fc_argmax #(.IN_W(IN_W), .N_OUT(N_OUT), .SC_W(SC_W), .CLS_W(CLS_W)) dut (
    .clk(clk), .reset(reset), .start_flag(start_flag), .in(in), .weight_in(weight_in),
    .class_out(class_out), .max_score(max_score), .score_out(score_out),
    .busy(busy), .end_flag(end_flag), .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: packs {class, max, scores}
  function automatic logic [W-1:0] model(input logic [IN_W-1:0] x, input logic [N_OUT*IN_W-1:0] wb);
    logic [SC_W-1:0]       best = '0;
    logic [CLS_W-1:0]      cls = '0;
    logic [N_OUT*SC_W-1:0] sc = '0;
    for (int k = 0; k < N_OUT; k++) begin
      logic [IN_W-1:0] w = wb[k*IN_W +: IN_W];
      int s = 0;
      for (int b = 0; b < IN_W; b++) if (x[b] == w[b]) s++;
      sc[k*SC_W +: SC_W] = SC_W'(s);
      if (k == 0 || SC_W'(s) > best) begin
        best = SC_W'(s);
        cls  = CLS_W'(k);
      end
    end
`ifndef BINARY_FC_SCORE_OUT_EN
    sc = '0;
`endif
    return {cls, best, sc};
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (end_flag) begin
      logic [W-1:0] e;
      ends_seen++;
      if (prev_end) check("end_pulse_width", 64'd1, 64'd0);
      if (exp_q.size() == 0) check("unexpected_end", 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        check("class_out", 64'(class_out), 64'(e[W-1 -: CLS_W]));
        check("max_score", 64'(max_score), 64'(e[N_OUT*SC_W +: SC_W]));
        check("score_out", 64'(score_out), 64'(e[N_OUT*SC_W-1:0]));
      end
    end
    prev_end <= end_flag;
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_all_w(input logic [IN_W-1:0] v);
    for (int k = 0; k < N_OUT; k++) weight_in[k*IN_W +: IN_W] = v;
  endtask

  task automatic start_frame(input logic [IN_W-1:0] x);
    in = x;
    start_flag = 1'b1;
    exp_q.push_back(model(x, weight_in));
    tick();
    start_flag = 1'b0;
    in = $urandom_range(0, 65535);
    t0 = cyc;
  endtask

  task automatic wait_end(output int latency);
    latency = -1;
    for (int i = 0; i < 30; i++) begin
      if (end_flag) begin
        latency = cyc - t0;
        break;
      end
      tick();
    end
    if (latency < 0) check("end_timeout", 64'd1, 64'd0);
  endtask

  task automatic run_frame(input string tag, input logic [IN_W-1:0] x);
    start_frame(x);
    wait_end(lat);
    check({tag, "_latency"}, 64'(lat), 64'd11);
    tick();
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int n;
    // Reset held with start asserted
    reset = 1'b0;
    start_flag = 1'b1;
    in = 16'hFFFF;
    repeat (3) tick();
    start_flag = 1'b0;
    check("rst_class", 64'(class_out), 64'd0);
    check("rst_max", 64'(max_score), 64'd0);
    check("rst_scores", 64'(score_out), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_end", 64'(end_flag), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);
    reset = 1'b1;
    tick();

    // Exact match on neuron 7
    set_all_w(16'h0000);
    weight_in[7*IN_W +: IN_W] = 16'hA5A5;
    run_frame("exact", 16'hA5A5);

    // All-equal scores: lowest index wins
    set_all_w(16'hFFFF);
    run_frame("tie", 16'h00FF);

    // Inverse / zero
    set_all_w(16'hFFFF);
    weight_in[3*IN_W +: IN_W] = 16'h0000;
    run_frame("inverse", 16'h0000);

    // Second start mid-frame is dropped; next start right after end is accepted
    for (int k = 0; k < N_OUT; k++) weight_in[k*IN_W +: IN_W] = IN_W'($urandom_range(0, 65535));
    start_frame(16'h1234);
    repeat (4) tick();
    check("busy_mid", 64'(busy), 64'd1);
    in = 16'hEDCB;
    start_flag = 1'b1;
    tick();
    start_flag = 1'b0;
    wait_end(lat);
    check("drop_latency", 64'(lat), 64'd11);
    n = ends_seen;
    start_frame(16'h0F0F);
    wait_end(lat);
    check("b2b_latency", 64'(lat), 64'd11);
    repeat (15) tick();
    check("drop_end_count", 64'(ends_seen - n), 64'd2);

    // Mid-frame reset aborts
    n = ends_seen;
    start_frame(16'h5555);
    repeat (5) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    exp_q.delete();
    check("abort_class", 64'(class_out), 64'd0);
    check("abort_max", 64'(max_score), 64'd0);
    check("abort_scores", 64'(score_out), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    repeat (15) tick();
    check("abort_no_end", 64'(ends_seen - n), 64'd0);
    run_frame("post_abort", 16'h5555);

    // Random frames
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < N_OUT; k++) weight_in[k*IN_W +: IN_W] = IN_W'($urandom_range(0, 65535));
      run_frame("rand", IN_W'($urandom_range(0, 65535)));
    end

    repeat (3) tick();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/binary_fc_argmax.md
Name: binary_fc_argmax

Overview:
- Binarized fully-connected classifier stage directly downstream of the 8-to-4 max-pooling slide stage.
- Consumes the 16-bit pooled 4x4 binary feature map and its one-cycle done pulse.
- Evaluates N_OUT neurons sequentially, one per cycle. Each score is popcount(XNOR(in, weight_k)).
- Emits the index of the highest-scoring neuron, its score, and an end pulse.

Parameters:
- IN_W, 16, feature vector width (pooled map bits)
- N_OUT, 10, number of output neurons/classes (2..16)
- SC_W, 5, score width; must hold IN_W (0..16)
- CLS_W, 4, class index width; must hold N_OUT-1

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (0 = reset)
- start_flag  input  1  one-cycle pulse; `in` valid in same cycle
- in  input  IN_W  binary feature vector; bit 15 = pooled pixel (0,0)
- weight_in  input  N_OUT*IN_W  static weight bank; neuron k at [k*IN_W +: IN_W]
- class_out  output  CLS_W  argmax neuron index
- max_score  output  SC_W  score of class_out
- score_out  output  N_OUT*SC_W  per-neuron scores; neuron k at [k*SC_W +: SC_W]
- busy  output  1  high while a frame is in progress
- end_flag  output  1  one-cycle result-valid pulse

Behaviour:
- Reset (reset==0 at a clock edge):
  - state goes to IDLE.
  - class_out, max_score, score_out, end_flag and busy all go to 0.
  - Internal counter, latched input and running max are cleared.
- FSM states:
  - IDLE: on start_flag=1, latch `in`, clear idx, run_max and run_cls, go to RUN; busy=1 from the next cycle.
  - RUN: each cycle:
    - compute s = popcount(~(in_lat ^ weight_in[idx])).
    - write s into score slot idx.
    - if idx==0 or s > run_max, set run_max=s and run_cls=idx.
    - idx increments. After idx==N_OUT-1 is processed, go to FINISH.
  - FINISH: load class_out=run_cls and max_score=run_max, set end_flag=1 and busy=0, go to IDLE.
- Latency: start sampled at edge E0; neuron k is scored at edge E(k+1); outputs and end_flag update at edge E(N_OUT+1). With defaults, end_flag is high for exactly one cycle, 11 cycles after start.
- Tie rule: strict greater-than, so the lowest index wins among equal scores.
- Score range: 0..IN_W. No saturation is needed; SC_W>=clog2(IN_W+1) is required.
- start_flag while in RUN or FINISH is ignored; the in-flight frame is unaffected and no queueing occurs.
- start_flag in the IDLE cycle immediately after FINISH is accepted, so back-to-back frames are possible at N_OUT+2 cycle spacing.
- Outputs hold their last values between frames. Only end_flag is a pulse.
- `in` and weight_in are don't-care outside the start cycle. weight_in must be stable from start until end_flag.
- Reset mid-RUN aborts the frame. No end_flag is produced and all outputs clear.

Optional Feature:
- Macro: BINARY_FC_SCORE_OUT_EN
- Defined:
  - score_out registers are implemented as described.
  - Scores update per neuron during RUN, so score_out is only coherent when end_flag=1.
- Undefined:
  - No per-neuron score storage is built; score_out is tied to 0.
  - class_out, max_score, end_flag and timing are identical to the defined case.

Test Plan:
- Reset: hold reset=0 for 3 cycles with start_flag=1 -> all outputs 0, busy=0, no end_flag.
- Exact match: weights k = 16'h0000 except neuron 7 = 16'hA5A5; in=16'hA5A5 -> end_flag exactly 11 cycles after start, class_out=7, max_score=16. With macro, neuron 7 score=16 and the others=8.
- Tie: all weights = 16'hFFFF, in=16'h00FF -> every score 8; class_out=0, max_score=8.
- Inverse/zero: in=16'h0000, neuron 3 = 16'h0000, the others 16'hFFFF -> class_out=3, max_score=16; with macro, the others score 0.
- Busy drop: second start_flag 4 cycles into a frame with different `in` -> single end_flag carrying the first frame's result. Next start immediately after end_flag is accepted, with end_flag 11 cycles later.
- Mid-frame reset: reset=0 at cycle 5 of RUN -> no end_flag, outputs 0. A fresh start afterwards gives the correct result.
